// File: rtl/servo_scan_ctrl.sv
// Servo scan controller: sweeps right/center/left, triggers the
// ultrasonic ranger at each stop and stores one distance per position.
module servo_scan_ctrl #(
  parameter int unsigned SETTLE_CYCLES  = 30_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 3_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [1:0]  pos,
  output logic        us_trig,
  input  logic        us_done,
  input  logic [15:0] us_dist,
  output logic [15:0] dist_r,
  output logic [15:0] dist_c,
  output logic [15:0] dist_l,
  output logic [2:0]  err,
  output logic        busy,
  output logic        done
);

  localparam int unsigned MAXC =
    (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] POS_R = 2'b00;
  localparam logic [1:0] POS_C = 2'b01;
  localparam logic [1:0] POS_L = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE,
    S_SETTLE,
    S_TRIG,
    S_WAIT,
    S_STORE,
    S_HOME
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  pos_q, pos_d;
  logic [15:0] dr_q, dr_d;
  logic [15:0] dc_q, dc_d;
  logic [15:0] dl_q, dl_d;
  logic [2:0]  err_q, err_d;

  logic        wr_en;
  logic [15:0] wr_val;
  logic        wr_err;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      pos_q   <= POS_C;
      dr_q    <= 16'd0;
      dc_q    <= 16'd0;
      dl_q    <= 16'd0;
      err_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      dr_q    <= dr_d;
      dc_q    <= dc_d;
      dl_q    <= dl_d;
      err_q   <= err_d;
    end
  end

  // Next-state, counters, result capture and strobes
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    dr_d    = dr_q;
    dc_d    = dc_q;
    dl_d    = dl_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    wr_val  = 16'd0;
    wr_err  = 1'b0;
    us_trig = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = 2'd0;
          state_d = S_MOVE;
        end
      end
      S_MOVE: begin
        unique case (idx_q)
          2'd1:    pos_d = POS_C;
          2'd2:    pos_d = POS_L;
          default: pos_d = POS_R;
        endcase
        cnt_d   = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_TRIG;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_TRIG: begin
        us_trig = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A reply on the terminal cycle still counts as a reply
        if (us_done) begin
          wr_en   = 1'b1;
          wr_val  = us_dist;
          wr_err  = 1'b0;
          state_d = S_STORE;
        end else if (cnt_q == TO_LAST) begin
          wr_en   = 1'b1;
          wr_val  = 16'hFFFF;
          wr_err  = 1'b1;
          state_d = S_STORE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STORE: begin
        if (idx_q == 2'd2) begin
          state_d = S_HOME;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = S_MOVE;
        end
      end
      S_HOME: begin
        pos_d   = POS_C;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (wr_en) begin
      case (idx_q)
        2'd0: begin
          dr_d     = wr_val;
          err_d[0] = wr_err;
        end
        2'd1: begin
          dc_d     = wr_val;
          err_d[1] = wr_err;
        end
        2'd2: begin
          dl_d     = wr_val;
          err_d[2] = wr_err;
        end
        default: ;
      endcase
    end
  end

  assign pos    = pos_q;
  assign dist_r = dr_q;
  assign dist_c = dc_q;
  assign dist_l = dl_q;
  assign err    = err_q;
  assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_servo_scan_ctrl.sv
// Directed bench for servo_scan_ctrl with a scripted ranger model.
// Small settle/timeout values keep scans short.
module tb_servo_scan_ctrl;

  localparam int S = 10;
  localparam int T = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_m = 1'b0;
  logic        start_x = 1'b0;
  logic        rng_done = 1'b0;
  logic        stray_done = 1'b0;
  logic [15:0] rng_dist = 16'd0;
  logic [15:0] stray_dist = 16'd0;

  logic        start;
  logic        us_done;
  logic [15:0] us_dist;
  logic [1:0]  pos;
  logic        us_trig;
  logic [15:0] dist_r, dist_c, dist_l;
  logic [2:0]  err;
  logic        busy, done;

  assign start   = start_m | start_x;
  assign us_done = rng_done | stray_done;
  assign us_dist = rng_done ? rng_dist : stray_dist;

  servo_scan_ctrl #(
    .SETTLE_CYCLES (S),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .pos    (pos),
    .us_trig(us_trig),
    .us_done(us_done),
    .us_dist(us_dist),
    .dist_r (dist_r),
    .dist_c (dist_c),
    .dist_l (dist_l),
    .err    (err),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Ranger script: reply delay (0 = silent) and value per position
  int          dly[3];
  logic [15:0] val[3];

  // Ranger: reply d cycles after each trigger pulse
  initial begin
    int k;
    int d;
    k = 0;
    forever begin
      @(negedge clk);
      if (us_trig === 1'b1) begin
        d = dly[k % 3];
        if (d > 0) begin
          repeat (d) @(negedge clk);
          rng_dist = val[k % 3];
          rng_done = 1'b1;
          @(negedge clk);
          rng_done = 1'b0;
        end
        k++;
      end
    end
  end

  // Monitor: trigger/done counts, pos history, settle gap
  int         trig_cnt = 0;
  int         done_cnt = 0;
  int         gap_bad = 0;
  int         since = 0;
  logic [7:0] pos_hist = 8'h00;
  logic [1:0] last_pos = 2'b01;

  initial begin
    forever begin
      @(negedge clk);
      if (pos !== last_pos) begin
        pos_hist = {pos_hist[5:0], pos};
        last_pos = pos;
        since = 0;
      end else begin
        since++;
      end
      if (us_trig === 1'b1) begin
        trig_cnt++;
        if (since != S) gap_bad++;
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  // Start one scan, return cycles from start cycle to done cycle
  task automatic run_scan(input int budget, output int lat);
    int n;
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    lat = n;
    repeat (2) @(negedge clk);
  endtask

  int t0, d0, g0, lat, n;

  initial begin
    // Reset held two cycles
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_pos", pos, 2'b01);
    check("rst_busy", busy, 1'b0);
    check("rst_dr", dist_r, 16'd0);
    check("rst_dc", dist_c, 16'd0);
    check("rst_dl", dist_l, 16'd0);
    check("rst_err", err, 3'b000);
    check("rst_trig", us_trig, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Normal scan: replies after 5 cycles each
    dly = '{5, 5, 5};
    val = '{16'd100, 16'd200, 16'd300};
    t0 = trig_cnt; d0 = done_cnt; g0 = gap_bad;
    run_scan(500, lat);
    check("n_lat", lat, 3 * (1 + S + 1 + 5 + 1) + 1);
    check("n_dr", dist_r, 16'd100);
    check("n_dc", dist_c, 16'd200);
    check("n_dl", dist_l, 16'd300);
    check("n_err", err, 3'b000);
    check("n_trigs", trig_cnt - t0, 3);
    check("n_dones", done_cnt - d0, 1);
    check("n_gap", gap_bad - g0, 0);
    check("n_pos_seq", pos_hist, 8'b00_01_10_01);
    check("n_busy", busy, 1'b0);
    check("n_pos_home", pos, 2'b01);

    // Silent at center: timeout path
    dly = '{5, 0, 5};
    val = '{16'd11, 16'd22, 16'd33};
    t0 = trig_cnt; d0 = done_cnt;
    run_scan(500, lat);
    check("t_lat", lat, 3 * (1 + S + 1 + 1) + 5 + T + 5 + 1);
    check("t_dr", dist_r, 16'd11);
    check("t_dc", dist_c, 16'hFFFF);
    check("t_dl", dist_l, 16'd33);
    check("t_err", err, 3'b010);
    check("t_dones", done_cnt - d0, 1);
    check("t_trigs", trig_cnt - t0, 3);

    // Reply on the terminal wait cycle at center
    dly = '{5, T, 5};
    val = '{16'd7, 16'd8, 16'd9};
    d0 = done_cnt;
    run_scan(500, lat);
    check("s_lat", lat, 3 * (1 + S + 1 + 1) + 5 + T + 5 + 1);
    check("s_dr", dist_r, 16'd7);
    check("s_dc", dist_c, 16'd8);
    check("s_dl", dist_l, 16'd9);
    check("s_err", err, 3'b000);
    check("s_dones", done_cnt - d0, 1);

    // Stray start and us_done during right settle
    dly = '{5, 5, 5};
    val = '{16'd1000, 16'd2000, 16'd3000};
    t0 = trig_cnt; d0 = done_cnt;
    fork
      begin
        repeat (4) @(negedge clk);
        stray_dist = 16'hDEAD;
        stray_done = 1'b1;
        start_x    = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        start_x    = 1'b0;
        check("i_hold_dr", dist_r, 16'd7);
        check("i_hold_err", err, 3'b000);
      end
    join_none
    run_scan(500, lat);
    check("i_lat", lat, 3 * (1 + S + 1 + 5 + 1) + 1);
    check("i_dr", dist_r, 16'd1000);
    check("i_dc", dist_c, 16'd2000);
    check("i_dl", dist_l, 16'd3000);
    check("i_err", err, 3'b000);
    check("i_dones", done_cnt - d0, 1);
    check("i_trigs", trig_cnt - t0, 3);

    // Reset while waiting at the left position
    dly = '{5, 5, 0};
    val = '{16'd1, 16'd2, 16'd3};
    t0 = trig_cnt; d0 = done_cnt;
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    n = 0;
    while (trig_cnt - t0 < 3 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("r_third_trig", trig_cnt - t0, 3);
    repeat (10) @(negedge clk);
    check("r_busy_pre", busy, 1'b1);
    check("r_pos_pre", pos, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("r_busy", busy, 1'b0);
    check("r_pos", pos, 2'b01);
    check("r_dr", dist_r, 16'd0);
    check("r_dc", dist_c, 16'd0);
    check("r_dl", dist_l, 16'd0);
    check("r_err", err, 3'b000);
    check("r_trig", us_trig, 1'b0);
    repeat (60) @(negedge clk);
    check("r_no_done", done_cnt - d0, 0);
    check("r_idle", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
